// File: rtl/sb_tx_msg_arbiter_if.sv
// LTSM/RDI request fields in, encoder-side message fields and acks out.
// slave = arbiter side, master = requester/framer side.
interface sb_tx_msg_arbiter_if;
    logic        i_clear;
    logic        i_ltsm_req;
    logic        i_ltsm_data_valid;
    logic [3:0]  i_ltsm_state;
    logic [3:0]  i_ltsm_sub_state;
    logic [3:0]  i_ltsm_msg_no;
    logic [15:0] i_ltsm_data_bus;
    logic        i_rdi_req;
    logic [3:0]  i_rdi_msg_no;
    logic        i_pkt_done;
    logic        o_msg_valid;
    logic        o_data_valid;
    logic [3:0]  o_state;
    logic [3:0]  o_sub_state;
    logic [3:0]  o_msg_no;
    logic [15:0] o_data_bus;
    logic        o_rdi_sel;
    logic        o_ltsm_ack;
    logic        o_rdi_ack;
    logic        o_tx_timeout;
    logic        o_busy;

    modport slave (
        input  i_clear, i_ltsm_req, i_ltsm_data_valid, i_ltsm_state, i_ltsm_sub_state,
               i_ltsm_msg_no, i_ltsm_data_bus, i_rdi_req, i_rdi_msg_no, i_pkt_done,
        output o_msg_valid, o_data_valid, o_state, o_sub_state, o_msg_no, o_data_bus,
               o_rdi_sel, o_ltsm_ack, o_rdi_ack, o_tx_timeout, o_busy
    );

    modport master (
        output i_clear, i_ltsm_req, i_ltsm_data_valid, i_ltsm_state, i_ltsm_sub_state,
               i_ltsm_msg_no, i_ltsm_data_bus, i_rdi_req, i_rdi_msg_no, i_pkt_done,
        input  o_msg_valid, o_data_valid, o_state, o_sub_state, o_msg_no, o_data_bus,
               o_rdi_sel, o_ltsm_ack, o_rdi_ack, o_tx_timeout, o_busy
    );
endinterface

// File: rtl/sb_tx_msg_arbiter.sv
// Round-robin LTSM/RDI sideband message arbiter; o_msg_valid one cycle after a request seen in IDLE.
// Requesters hold req until ack, which follows packet done or timeout; new requests wait out the gap.
module sb_tx_msg_arbiter #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sb_tx_msg_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE, GAP} state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        last_rdi_q, last_rdi_d;
    logic        msg_valid_q, msg_valid_d;
    logic        data_valid_q, data_valid_d;
    logic [3:0]  state_o_q, state_o_d;
    logic [3:0]  sub_state_q, sub_state_d;
    logic [3:0]  msg_no_q, msg_no_d;
    logic [15:0] data_bus_q, data_bus_d;
    logic        rdi_sel_q, rdi_sel_d;
    logic        ltsm_ack_q, ltsm_ack_d;
    logic        rdi_ack_q, rdi_ack_d;
    logic        tx_timeout_q, tx_timeout_d;
    logic        busy_q, busy_d;
    logic        pick_rdi;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_rdi_d   = last_rdi_q;
        msg_valid_d  = 1'b0;
        ltsm_ack_d   = 1'b0;
        rdi_ack_d    = 1'b0;
        tx_timeout_d = 1'b0;
        data_valid_d = data_valid_q;
        state_o_d    = state_o_q;
        sub_state_d  = sub_state_q;
        msg_no_d     = msg_no_q;
        data_bus_d   = data_bus_q;
        rdi_sel_d    = rdi_sel_q;
        pick_rdi     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_ltsm_req || bus.i_rdi_req) begin
                    // On a tie, RDI wins only if LTSM was granted last.
                    pick_rdi     = bus.i_rdi_req && (!bus.i_ltsm_req || !last_rdi_q);
                    state_d      = GRANT;
                    msg_valid_d  = 1'b1;
                    wait_cnt_d   = 16'd0;
                    last_rdi_d   = pick_rdi;
                    rdi_sel_d    = pick_rdi;
                    if (pick_rdi) begin
                        data_valid_d = 1'b0;
                        state_o_d    = 4'd0;
                        sub_state_d  = 4'd0;
                        msg_no_d     = bus.i_rdi_msg_no;
                        data_bus_d   = 16'd0;
                    end else begin
                        data_valid_d = bus.i_ltsm_data_valid;
                        state_o_d    = bus.i_ltsm_state;
                        sub_state_d  = bus.i_ltsm_sub_state;
                        msg_no_d     = bus.i_ltsm_msg_no;
                        data_bus_d   = bus.i_ltsm_data_bus;
                    end
                end
            end
            GRANT: state_d = WAIT_DONE;
            WAIT_DONE: begin
                // A done pulse in the last allowed cycle still counts as done, not timeout.
                if (bus.i_pkt_done || (wait_cnt_q == TO_LAST)) begin
                    state_d      = GAP;
                    gap_cnt_d    = 8'd0;
                    ltsm_ack_d   = !rdi_sel_q;
                    rdi_ack_d    = rdi_sel_q;
                    tx_timeout_d = !bus.i_pkt_done;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = 8'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear drops the in-flight message but leaves last-grant and the presented fields alone.
        if (bus.i_clear) begin
            state_d      = IDLE;
            wait_cnt_d   = 16'd0;
            gap_cnt_d    = 8'd0;
            last_rdi_d   = last_rdi_q;
            msg_valid_d  = 1'b0;
            ltsm_ack_d   = 1'b0;
            rdi_ack_d    = 1'b0;
            tx_timeout_d = 1'b0;
            data_valid_d = data_valid_q;
            state_o_d    = state_o_q;
            sub_state_d  = sub_state_q;
            msg_no_d     = msg_no_q;
            data_bus_d   = data_bus_q;
            rdi_sel_d    = rdi_sel_q;
        end

        busy_d = (state_d == GRANT) || (state_d == WAIT_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 16'd0;
            gap_cnt_q    <= 8'd0;
            last_rdi_q   <= 1'b1;
            msg_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            state_o_q    <= 4'd0;
            sub_state_q  <= 4'd0;
            msg_no_q     <= 4'd0;
            data_bus_q   <= 16'd0;
            rdi_sel_q    <= 1'b0;
            ltsm_ack_q   <= 1'b0;
            rdi_ack_q    <= 1'b0;
            tx_timeout_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_rdi_q   <= last_rdi_d;
            msg_valid_q  <= msg_valid_d;
            data_valid_q <= data_valid_d;
            state_o_q    <= state_o_d;
            sub_state_q  <= sub_state_d;
            msg_no_q     <= msg_no_d;
            data_bus_q   <= data_bus_d;
            rdi_sel_q    <= rdi_sel_d;
            ltsm_ack_q   <= ltsm_ack_d;
            rdi_ack_q    <= rdi_ack_d;
            tx_timeout_q <= tx_timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.o_msg_valid  = msg_valid_q;
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_state      = state_o_q;
    assign bus.o_sub_state  = sub_state_q;
    assign bus.o_msg_no     = msg_no_q;
    assign bus.o_data_bus   = data_bus_q;
    assign bus.o_rdi_sel    = rdi_sel_q;
    assign bus.o_ltsm_ack   = ltsm_ack_q;
    assign bus.o_rdi_ack    = rdi_ack_q;
    assign bus.o_tx_timeout = tx_timeout_q;
    assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// Bench for sb_tx_msg_arbiter: directed scenarios plus random traffic against a
// transaction-level model of round-robin grants, done/timeout acks and gap spacing.
module tb_sb_tx_msg_arbiter;
    localparam int GAP = 4;
    localparam int TO  = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   model_last_rdi;

    sb_tx_msg_arbiter_if bus ();

    sb_tx_msg_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] all_outs();
        return {bus.o_msg_valid, bus.o_data_valid, bus.o_state, bus.o_sub_state, bus.o_msg_no,
                bus.o_data_bus, bus.o_rdi_sel, bus.o_ltsm_ack, bus.o_rdi_ack, bus.o_tx_timeout,
                bus.o_busy};
    endfunction

    function automatic logic [29:0] fields();
        return {bus.o_data_valid, bus.o_state, bus.o_sub_state, bus.o_msg_no, bus.o_data_bus,
                bus.o_rdi_sel};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ltsm(input logic dv, input logic [3:0] st, input logic [3:0] sub,
                            input logic [3:0] msg, input logic [15:0] dat);
        bus.i_ltsm_req         = 1'b1;
        bus.i_ltsm_data_valid  = dv;
        bus.i_ltsm_state       = st;
        bus.i_ltsm_sub_state   = sub;
        bus.i_ltsm_msg_no      = msg;
        bus.i_ltsm_data_bus    = dat;
    endtask

    task automatic set_rdi(input logic [3:0] msg);
        bus.i_rdi_req    = 1'b1;
        bus.i_rdi_msg_no = msg;
    endtask

    task automatic do_reset();
        bus.i_ltsm_req = 1'b0;
        bus.i_rdi_req  = 1'b0;
        bus.i_clear    = 1'b0;
        bus.i_pkt_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_outs", 64'(all_outs()), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        model_last_rdi = 1'b1;
    endtask

    // One full message: DUT must be in IDLE now with the requests already driven.
    // D = cycles after the grant cycle at which i_pkt_done is pulsed (0 lands in GRANT).
    task automatic run_txn(input int d, input bit drop_winner);
        bit           l, r, win_rdi, to;
        int           e;
        logic [29:0]  exp_f;
        l = bus.i_ltsm_req;
        r = bus.i_rdi_req;
        win_rdi = (l && r) ? !model_last_rdi : r;
        model_last_rdi = win_rdi;
        if (win_rdi) exp_f = {1'b0, 4'h0, 4'h0, bus.i_rdi_msg_no, 16'h0, 1'b1};
        else         exp_f = {bus.i_ltsm_data_valid, bus.i_ltsm_state, bus.i_ltsm_sub_state,
                              bus.i_ltsm_msg_no, bus.i_ltsm_data_bus, 1'b0};
        tick();
        chk("grant_valid_busy", 64'({bus.o_msg_valid, bus.o_busy}), 64'b11);
        chk("grant_fields", 64'(fields()), 64'(exp_f));
        to = (d < 1) || (d > TO);
        e  = to ? TO : d;
        for (int c = 0; c <= e; c++) begin
            bus.i_pkt_done = (c == d);
            tick();
            chk("wait_ack_to_busy_valid",
                64'({bus.o_ltsm_ack, bus.o_rdi_ack, bus.o_tx_timeout, bus.o_busy, bus.o_msg_valid}),
                64'({(c == e) && !win_rdi, (c == e) && win_rdi, (c == e) && to, c != e, 1'b0}));
        end
        chk("fields_stable", 64'(fields()), 64'(exp_f));
        if (drop_winner) begin
            if (win_rdi) bus.i_rdi_req = 1'b0;
            else         bus.i_ltsm_req = 1'b0;
        end
        for (int i = 1; i <= GAP; i++) begin
            bus.i_pkt_done = 1'($urandom_range(0, 1));
            tick();
            chk("gap_quiet",
                64'({bus.o_msg_valid, bus.o_ltsm_ack, bus.o_rdi_ack, bus.o_tx_timeout, bus.o_busy}),
                64'd0);
        end
        bus.i_pkt_done = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.i_ltsm_data_valid = 1'b0;
        bus.i_ltsm_state      = 4'h0;
        bus.i_ltsm_sub_state  = 4'h0;
        bus.i_ltsm_msg_no     = 4'h0;
        bus.i_ltsm_data_bus   = 16'h0;
        bus.i_rdi_msg_no      = 4'h0;
        do_reset();

        // Idle with no requests stays quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_outs", 64'(all_outs()), 64'd0);
        end

        // Basic LTSM message, acked one cycle after done.
        set_ltsm(1'b1, 4'd3, 4'd0, 4'd2, 16'h07FF);
        run_txn(3, 1'b1);

        // Both held, done 5 cycles after each grant: LTSM, RDI, LTSM from reset.
        do_reset();
        set_ltsm(1'b1, 4'd5, 4'd1, 4'd9, 16'hBEEF);
        set_rdi(4'd7);
        for (int k = 0; k < 3; k++) begin
            run_txn(5, 1'b0);
            chk("rr_order", 64'(model_last_rdi), 64'(k % 2));
        end
        bus.i_ltsm_req = 1'b0;
        bus.i_rdi_req  = 1'b0;

        // Timeouts: no done at all, and a done that lands in GRANT is ignored.
        set_ltsm(1'b0, 4'd1, 4'd2, 4'd3, 16'h1234);
        run_txn(TO + 2, 1'b1);
        set_rdi(4'd4);
        run_txn(0, 1'b1);
        set_ltsm(1'b1, 4'd6, 4'd6, 4'd6, 16'h6666);
        run_txn(TO, 1'b1);

        // Clear with done in the same WAIT_DONE cycle: clear wins, no ack.
        set_ltsm(1'b1, 4'd2, 4'd2, 4'd2, 16'h2222);
        tick();
        chk("clr_grant", 64'(bus.o_msg_valid), 64'd1);
        model_last_rdi = 1'b0;
        tick();
        bus.i_clear    = 1'b1;
        bus.i_pkt_done = 1'b1;
        tick();
        chk("clr_outs",
            64'({bus.o_msg_valid, bus.o_ltsm_ack, bus.o_rdi_ack, bus.o_tx_timeout, bus.o_busy}),
            64'd0);
        bus.i_clear    = 1'b0;
        bus.i_pkt_done = 1'b0;
        bus.i_ltsm_req = 1'b0;
        tick();
        chk("clr_idle", 64'({bus.o_msg_valid, bus.o_busy}), 64'd0);
        // Last grant survives clear, so a tie now goes to RDI, then the held LTSM.
        set_ltsm(1'b1, 4'd8, 4'd8, 4'd8, 16'h8888);
        set_rdi(4'd1);
        run_txn(2, 1'b1);
        chk("clr_tie_rdi", 64'(bus.o_rdi_sel), 64'd1);
        run_txn(2, 1'b1);

        // Async reset during WAIT_DONE, then an RDI message from IDLE.
        set_ltsm(1'b1, 4'hF, 4'hF, 4'hF, 16'hFFFF);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 64'(all_outs()), 64'd0);
        bus.i_ltsm_req = 1'b0;
        model_last_rdi = 1'b1;
        tick();
        rst_n = 1'b1;
        set_rdi(4'd5);
        run_txn(3, 1'b1);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            if (bus.i_ltsm_req && ($urandom_range(0, 3) == 0)) bus.i_ltsm_req = 1'b0;
            if (bus.i_rdi_req && ($urandom_range(0, 3) == 0)) bus.i_rdi_req = 1'b0;
            if (!bus.i_ltsm_req && ($urandom_range(0, 1) == 1))
                set_ltsm(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
            if (!bus.i_rdi_req && ($urandom_range(0, 1) == 1))
                set_rdi(4'($urandom));
            if (!bus.i_ltsm_req && !bus.i_rdi_req)
                set_ltsm(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
            run_txn($urandom_range(0, TO + 2), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
